// File: rtl/bcd_share_scheduler.sv
// Time-shares one binary-to-BCD converter across three counter channels, caching each result.
// Latency: value change to bcd_i update is 4 + converter latency cycles when idle.
// Backpressure: changes are queued as pending bits and served round-robin; WAIT gives up after TIMEOUT cycles.
module bcd_share_scheduler #(
    parameter int WIDTH         = 8,
    parameter int REFRESH_TICKS = 100000,
    parameter int TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value_0,
    input  logic [WIDTH-1:0] value_1,
    input  logic [WIDTH-1:0] value_2,
    output logic             conv_start,
    output logic [WIDTH-1:0] conv_bin,
    input  logic             conv_done,
    input  logic [11:0]      conv_bcd,
    output logic [11:0]      bcd_0,
    output logic [11:0]      bcd_1,
    output logic [11:0]      bcd_2,
    output logic [2:0]       valid,
    output logic             busy,
    output logic             err
);

    localparam int RW = $clog2(REFRESH_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    state_t                  state, state_nxt;
    logic [2:0][WIDTH-1:0]   val;
    logic [2:0][WIDTH-1:0]   snap;
    logic [2:0]              pending;
    logic [2:0]              chg;
    logic [2:0]              clr;
    logic [RW-1:0]           refresh_cnt;
    logic                    refresh_hit;
    logic [1:0]              gnt;
    logic [1:0]              last_gnt;
    logic [1:0]              pick;
    logic                    pick_vld;
    logic [TW-1:0]           timer;
    logic [11:0]             cap_bcd;
    logic                    load;
    logic                    store;
    logic                    tmo;

    assign val         = {value_2, value_1, value_0};
    assign refresh_hit = (refresh_cnt == RW'(REFRESH_TICKS - 1));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            chg[i] = (val[i] != snap[i]);
        end
    end

    // Search starts just after the last granted channel; lowest offset wins.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            if (pending[(int'(last_gnt) + k) % 3]) begin
                pick     = 2'((int'(last_gnt) + k) % 3);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        tmo        = 1'b0;
        clr        = 3'b000;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                conv_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    state_nxt = STORE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            STORE: begin
                store     = 1'b1;
                state_nxt = IDLE;
                // A value that moved during conversion keeps its request alive.
                if (val[gnt] == conv_bin) begin
                    clr[gnt] = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            snap        <= '0;
            pending     <= 3'b111;
            refresh_cnt <= '0;
            gnt         <= 2'd0;
            last_gnt    <= 2'd2;
            conv_bin    <= '0;
            timer       <= '0;
            cap_bcd     <= '0;
            bcd_0       <= '0;
            bcd_1       <= '0;
            bcd_2       <= '0;
            valid       <= 3'b000;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            snap        <= val;
            refresh_cnt <= refresh_hit ? '0 : refresh_cnt + 1'b1;
            pending     <= (pending & ~clr) | chg | {3{refresh_hit}};
            timer       <= (state == WAIT) ? timer + 1'b1 : '0;
            if (load) begin
                gnt      <= pick;
                conv_bin <= val[pick];
            end
            if (state == WAIT && conv_done) begin
                cap_bcd <= conv_bcd;
            end
            if (store) begin
                case (gnt)
                    2'd0:    bcd_0 <= cap_bcd;
                    2'd1:    bcd_1 <= cap_bcd;
                    default: bcd_2 <= cap_bcd;
                endcase
                valid[gnt] <= 1'b1;
                last_gnt   <= gnt;
            end
            if (tmo) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_share_scheduler.sv
// Bench for bcd_share_scheduler: directed sequences, a vector table and randomized value churn.
module tb_bcd_share_scheduler;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [7:0]  value_0, value_1, value_2;
    logic        conv_start, busy, err;
    logic [7:0]  conv_bin;
    wire         conv_done;
    wire  [11:0] conv_bcd;
    logic [11:0] bcd_0, bcd_1, bcd_2;
    logic [2:0]  valid;
    logic        model_done, inj_done, conv_en;
    logic [11:0] model_bcd;

    logic [7:0]  v2_0, v2_1, v2_2;
    logic        conv_start2, busy2, err2, model_done2;
    logic [7:0]  conv_bin2;
    logic [11:0] model_bcd2, bcd2_0, bcd2_1, bcd2_2;
    logic [2:0]  valid2;

    int total = 0;
    int bad   = 0;
    logic done2 = 1'b0;
    logic [7:0] start_log[$];

    assign conv_done = model_done | inj_done;
    assign conv_bcd  = inj_done ? 12'hbad : model_bcd;

    always #5 clk = ~clk;

    bcd_share_scheduler #(.WIDTH(8), .REFRESH_TICKS(100000), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .value_0(value_0), .value_1(value_1), .value_2(value_2),
        .conv_start(conv_start), .conv_bin(conv_bin), .conv_done(conv_done), .conv_bcd(conv_bcd),
        .bcd_0(bcd_0), .bcd_1(bcd_1), .bcd_2(bcd_2), .valid(valid), .busy(busy), .err(err));

    bcd_share_scheduler #(.WIDTH(8), .REFRESH_TICKS(50), .TIMEOUT(64)) dut2 (
        .clk(clk), .rst_n(rst2_n), .value_0(v2_0), .value_1(v2_1), .value_2(v2_2),
        .conv_start(conv_start2), .conv_bin(conv_bin2), .conv_done(model_done2), .conv_bcd(model_bcd2),
        .bcd_0(bcd2_0), .bcd_1(bcd2_1), .bcd_2(bcd2_2), .valid(valid2), .busy(busy2), .err(err2));

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (conv_start) break;
        end
        if (k == 300) check({name, "_start_timeout"}, 0, 1);
    endtask

    // Converter models: fixed latency, reset together with the scheduler they serve.
    int cnt = 0, cnt2 = 0;
    logic [7:0] bin_lat, bin_lat2;
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_done = 1'b1;
                    model_bcd  = to_bcd(int'(bin_lat));
                end
            end
            if (conv_start && conv_en) begin
                cnt     = LAT;
                bin_lat = conv_bin;
            end
        end
    end

    always @(negedge clk) begin
        model_done2 = 1'b0;
        if (!rst2_n) begin
            cnt2 = 0;
        end else begin
            if (cnt2 > 0) begin
                cnt2--;
                if (cnt2 == 0) begin
                    model_done2 = 1'b1;
                    model_bcd2  = to_bcd(int'(bin_lat2));
                end
            end
            if (conv_start2) begin
                cnt2     = LAT;
                bin_lat2 = conv_bin2;
            end
        end
    end

    // Operand must not move while a conversion is in flight.
    logic       prev_busy = 1'b0;
    logic [7:0] prev_bin  = 8'd0;
    always @(negedge clk) begin
        if (conv_start) start_log.push_back(conv_bin);
        if (busy && prev_busy) check("bin_stable", int'(conv_bin), int'(prev_bin));
        prev_busy = busy;
        prev_bin  = conv_bin;
    end

    typedef struct {
        logic [7:0]  v0, v1, v2;
        logic [11:0] e0, e1, e2;
    } vec_t;
    vec_t tbl[4];

    initial begin
        v2_0 = 8'd33; v2_1 = 8'd44; v2_2 = 8'd55;
        rst2_n = 1'b0;
        tick(2);
        rst2_n = 1'b1;
        tick(100);
        begin
            int n = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (conv_start2) n++;
            end
            check("refresh_starts_200cyc", n, 12);
        end
        check("refresh_bcd0", int'(bcd2_0), 12'h033);
        check("refresh_bcd1", int'(bcd2_1), 12'h044);
        check("refresh_bcd2", int'(bcd2_2), 12'h055);
        check("refresh_valid", int'(valid2), 3'b111);
        check("refresh_err", int'(err2), 0);
        done2 = 1'b1;
    end

    initial begin
        tbl[0] = '{8'd9,   8'd99, 8'd255, 12'h009, 12'h099, 12'h255};
        tbl[1] = '{8'd100, 8'd101, 8'd250, 12'h100, 12'h101, 12'h250};
        tbl[2] = '{8'd0,   8'd1,  8'd2,   12'h000, 12'h001, 12'h002};
        tbl[3] = '{8'd128, 8'd64, 8'd32,  12'h128, 12'h064, 12'h032};

        rst_n = 1'b0; conv_en = 1'b1; inj_done = 1'b0;
        value_0 = 8'd5; value_1 = 8'd17; value_2 = 8'd200;
        tick(3);
        check("rst_conv_start", int'(conv_start), 0);
        check("rst_conv_bin", int'(conv_bin), 0);
        check("rst_bcd0", int'(bcd_0), 0);
        check("rst_bcd1", int'(bcd_1), 0);
        check("rst_bcd2", int'(bcd_2), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);

        // First service after reset: channels in order 0,1,2.
        start_log.delete();
        rst_n = 1'b1;
        tick(60);
        check("init_nstarts", start_log.size(), 3);
        if (start_log.size() == 3) begin
            check("init_order0", int'(start_log[0]), 5);
            check("init_order1", int'(start_log[1]), 17);
            check("init_order2", int'(start_log[2]), 200);
        end
        check("init_bcd0", int'(bcd_0), 12'h005);
        check("init_bcd1", int'(bcd_1), 12'h017);
        check("init_bcd2", int'(bcd_2), 12'h200);
        check("init_valid", int'(valid), 3'b111);

        // Idle latency: 4 + converter latency.
        value_2 = 8'd199;
        begin
            int lat;
            for (lat = 1; lat <= 100; lat++) begin
                @(negedge clk);
                if (bcd_2 == 12'h199) break;
            end
            check("idle_latency", lat, 4 + LAT);
        end
        tick(10);

        // Channel 1 changes while channel 0 converts; served before channel 2.
        start_log.delete();
        value_0 = 8'd7; value_2 = 8'd201;
        wait_start("rr");
        tick(3);
        value_1 = 8'd18;
        tick(60);
        check("rr_nstarts", start_log.size(), 3);
        if (start_log.size() == 3) begin
            check("rr_order0", int'(start_log[0]), 7);
            check("rr_order1", int'(start_log[1]), 18);
            check("rr_order2", int'(start_log[2]), 201);
        end
        check("rr_bcd1", int'(bcd_1), 12'h018);
        check("rr_bcd2", int'(bcd_2), 12'h201);

        // Own value changes mid-conversion: a second conversion follows.
        start_log.delete();
        value_0 = 8'd5;
        wait_start("self");
        tick(3);
        value_0 = 8'd6;
        tick(60);
        check("self_nstarts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            check("self_first", int'(start_log[0]), 5);
            check("self_second", int'(start_log[1]), 6);
        end
        check("self_bcd0", int'(bcd_0), 12'h006);

        // Converter silent: timeout, then retry of the same channel.
        start_log.delete();
        conv_en = 1'b0;
        value_2 = 8'd202;
        wait_start("tmo");
        begin
            int n;
            for (n = 1; n <= 200; n++) begin
                @(negedge clk);
                if (err) break;
            end
            check("tmo_cycles", n, 64 + 1);
        end
        check("tmo_busy", int'(busy), 0);
        conv_en  = 1'b1;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("late_done_bcd2", int'(bcd_2), 12'h201);
        check("late_done_valid", int'(valid), 3'b111);
        tick(40);
        check("tmo_err_sticky", int'(err), 1);
        check("retry_bcd2", int'(bcd_2), 12'h202);
        check("retry_nstarts", start_log.size(), 2);
        if (start_log.size() == 2) check("retry_same_ch", int'(start_log[1]), 202);

        foreach (tbl[i]) begin
            value_0 = tbl[i].v0; value_1 = tbl[i].v1; value_2 = tbl[i].v2;
            tick(100);
            check($sformatf("tbl%0d_bcd0", i), int'(bcd_0), int'(tbl[i].e0));
            check($sformatf("tbl%0d_bcd1", i), int'(bcd_1), int'(tbl[i].e1));
            check($sformatf("tbl%0d_bcd2", i), int'(bcd_2), int'(tbl[i].e2));
            check($sformatf("tbl%0d_busy", i), int'(busy), 0);
        end

        // Random churn: once quiet, every cache holds its channel's current value.
        for (int it = 0; it < 15; it++) begin
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       value_0 = 8'($urandom_range(0, 255));
                        1:       value_1 = 8'($urandom_range(0, 255));
                        default: value_2 = 8'($urandom_range(0, 255));
                    endcase
                end
            end
            tick(130);
            check($sformatf("rnd%0d_bcd0", it), int'(bcd_0), int'(to_bcd(int'(value_0))));
            check($sformatf("rnd%0d_bcd1", it), int'(bcd_1), int'(to_bcd(int'(value_1))));
            check($sformatf("rnd%0d_bcd2", it), int'(bcd_2), int'(to_bcd(int'(value_2))));
        end
        check("rnd_err_sticky", int'(err), 1);

        // Reset during channel 1's WAIT.
        value_0 = 8'd5; value_1 = 8'd17; value_2 = 8'd200;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        wait_start("mid0");
        tick(1);
        wait_start("mid1");
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bcd0", int'(bcd_0), 0);
        check("mid_rst_bcd1", int'(bcd_1), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_bin", int'(conv_bin), 0);
        tick(2);
        start_log.delete();
        rst_n = 1'b1;
        tick(60);
        check("restart_nstarts", start_log.size(), 3);
        if (start_log.size() == 3) check("restart_first", int'(start_log[0]), 5);
        check("restart_bcd0", int'(bcd_0), 12'h005);
        check("restart_bcd1", int'(bcd_1), 12'h017);
        check("restart_bcd2", int'(bcd_2), 12'h200);
        check("restart_valid", int'(valid), 3'b111);

        begin
            int w;
            for (w = 0; w < 2000 && !done2; w++) @(negedge clk);
            if (!done2) check("refresh_done_timeout", 0, 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
